gmac_tx_feeder: RTL and testbench
=================================

Name: gmac_tx_feeder

Overview:
Client-side transmit source for the custom GMAC transmit channel, running in the clk125 domain.
- Accepts a payload byte stream from the application and stores one packet in an internal buffer.
- Requests a slot from the MAC with a Req/Confirm handshake, then streams the packet as Val/SoF/EoF/Data bytes into the MAC's channel-0 input.
- It is the producer end of the interface that the MAC's transmit path consumes.

Parameters:
DEPTH, 1472, buffer size in bytes (maximum UDP payload per packet).
AW, 11, buffer address width; 2**AW >= DEPTH.
REQ_TIMEOUT, 4096, clk125 cycles to wait for ReqConfirm before the packet is dropped.
IFG_CYC, 12, idle cycles after EoF before the next request may be raised.

Ports:
clk125  in  1  sole clock.
rstn  in  1  synchronous active-low reset.
wr_en  in  1  payload byte valid.
wr_data  in  8  payload byte.
wr_last  in  1  marks the final byte of a packet; qualified by wr_en.
wr_ready  out  1  high when the buffer accepts bytes.
ReqOut  out  1  transmit request to the MAC (drives ReqIn0).
ReqConfirm  in  1  MAC grant for the request.
ValOut  out  1  byte valid to the MAC (drives ValIn0).
SoFOut  out  1  first byte of packet (drives SoFIn0).
EoFOut  out  1  last byte of packet (drives EoFIn0).
DataOut  out  8  byte to the MAC (drives DataIn0).
busy  out  1  high in any state other than IDLE.
tx_pkt_cnt  out  16  packets fully sent; wraps at 2^16.
drop_cnt  out  16  packets dropped (overflow or timeout); wraps at 2^16.

Behaviour:
- Reset (rstn low at a clk125 edge):
  - State goes to IDLE.
  - ReqOut, ValOut, SoFOut, EoFOut = 0; DataOut = 0.
  - wr_ready = 1; counters = 0; write pointer and length = 0.
  - Reset mid-packet discards the packet. No EoF is emitted.
- States: IDLE, FILL, REQ, SEND, GAP.
- IDLE:
  - wr_en stores the byte at address 0 and sets len = 1.
  - If wr_last is also high, go to REQ. Otherwise go to FILL.
- FILL:
  - Each wr_en stores at address len and increments len.
  - wr_en with wr_last goes to REQ.
  - A byte arriving when len == DEPTH sets an overflow flag and the byte is not stored.
  - When wr_last arrives with the overflow flag set: drop_cnt += 1, clear the flag, go to IDLE. No request is raised.
- wr_ready = 1 only in IDLE and FILL. wr_en while wr_ready = 0 is ignored (not counted, not stored).
- REQ:
  - ReqOut = 1 from the cycle after entry, held until ReqConfirm is sampled high.
  - The timeout counter starts at 0 on entry.
  - ReqConfirm sampled high: ReqOut drops in the next cycle and the state goes to SEND.
  - Counter reaching REQ_TIMEOUT-1 without a grant: drop_cnt += 1, go to IDLE.
  - ReqConfirm in the same cycle as the timeout: the grant wins.
  - ReqConfirm outside REQ is ignored.
- SEND:
  - The buffer has 1-cycle read latency. The first byte appears on DataOut 2 cycles after ReqConfirm is sampled.
  - One byte per cycle with ValOut = 1, no gaps, len bytes total.
  - SoFOut = 1 with the byte at address 0 only. EoFOut = 1 with the byte at address len-1 only.
  - len == 1 asserts SoFOut and EoFOut together.
  - After the EoF cycle: tx_pkt_cnt += 1, go to GAP.
- GAP: IFG_CYC cycles with all outputs low, then IDLE.
- Outputs are registered. SoFOut, EoFOut and DataOut are 0 whenever ValOut = 0.
- Counters are plain modulo-2^16 (0xFFFF + 1 -> 0x0000).

Decomposition:
- Package gmac_tx_pkg: state enum; default DEPTH, IFG_CYC and REQ_TIMEOUT constants.
- Sub-module gmac_tx_buf: simple dual-port RAM, 8 x 2**AW, one write port and one registered read port, inferable as BRAM.
- All control logic stays in gmac_tx_feeder.

Test Plan:
- 4-byte packet 0x11,0x22,0x33,0x44 (wr_last on 0x44), ReqConfirm pulsed 5 cycles after ReqOut rises:
  - ReqOut falls the cycle after the grant.
  - ValOut is high for 4 consecutive cycles starting 2 cycles after the grant; bytes appear in order.
  - SoF on 0x11, EoF on 0x44; tx_pkt_cnt = 1.
- Single byte 0xA5 with wr_en and wr_last together:
  - One ValOut cycle with SoFOut = EoFOut = 1 and DataOut = 0xA5.
  - wr_ready is low from REQ until IFG_CYC = 12 cycles after that EoF.
- 1473-byte write with DEPTH = 1472:
  - ReqOut never rises; drop_cnt = 1; wr_ready returns to 1.
  - A following 2-byte packet sends correctly.
- ReqConfirm held low:
  - ReqOut stays high for exactly REQ_TIMEOUT = 4096 cycles, then drops.
  - drop_cnt = 1; no ValOut activity.
- rstn low for 1 cycle during SEND at byte 3 of 10:
  - Next cycle all outputs = 0 with no EoFOut; counters = 0.
  - A new packet then transmits normally.
- Back-to-back: second packet written during GAP is ignored (wr_ready = 0); the same packet written after GAP is sent; tx_pkt_cnt = 2.

Source files
------------

// File: rtl/gmac_tx_pkg.sv
// Shared types and defaults for the GMAC transmit feeder.
package gmac_tx_pkg;

  localparam int DEPTH_DEF       = 1472;
  localparam int AW_DEF          = 11;
  localparam int REQ_TIMEOUT_DEF = 4096;
  localparam int IFG_CYC_DEF     = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_REQ,
    ST_SEND,
    ST_GAP
  } tx_state_e;

  // Bits needed to hold any value in 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/gmac_tx_buf.sv
// Single-packet byte buffer: one write port, one registered read port.
module gmac_tx_buf
  import gmac_tx_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/gmac_tx_feeder.sv
// Buffers one application packet, requests a MAC slot, then streams it out.
//   state | meaning
//   IDLE  | waiting for the first payload byte
//   FILL  | collecting bytes until wr_last
//   REQ   | ReqOut high, waiting for ReqConfirm or timeout
//   SEND  | streaming len bytes with Val/SoF/EoF
//   GAP   | inter-frame idle before the next packet
module gmac_tx_feeder
  import gmac_tx_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEF,
  parameter int AW          = AW_DEF,
  parameter int REQ_TIMEOUT = REQ_TIMEOUT_DEF,
  parameter int IFG_CYC     = IFG_CYC_DEF
) (
  input  logic        clk125,
  input  logic        rstn,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        wr_last,
  output logic        wr_ready,
  output logic        ReqOut,
  input  logic        ReqConfirm,
  output logic        ValOut,
  output logic        SoFOut,
  output logic        EoFOut,
  output logic [7:0]  DataOut,
  output logic        busy,
  output logic [15:0] tx_pkt_cnt,
  output logic [15:0] drop_cnt
);

  localparam int TW = cnt_width(REQ_TIMEOUT);
  localparam int GW = cnt_width(IFG_CYC);

  tx_state_e     state_q;
  logic [AW-1:0] len_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] out_idx_q;
  logic          ovf_q;
  logic [TW-1:0] tmr_q;
  logic [GW-1:0] gap_q;
  logic          req_q;
  logic          val_q;
  logic          sof_q;
  logic          eof_q;
  logic [7:0]    data_q;
  logic [15:0]   tx_cnt_q;
  logic [15:0]   drop_cnt_q;

  logic          buf_full_d;
  logic          ovf_d;
  logic          last_byte_d;
  logic          tmr_done_d;
  logic          gap_done_d;
  logic          mem_we_d;
  logic [AW-1:0] mem_waddr_d;
  logic [7:0]    rd_data;

  always_comb begin
    buf_full_d  = (len_q == AW'(DEPTH));
    ovf_d       = ovf_q | buf_full_d;
    last_byte_d = (out_idx_q == len_q - AW'(1));
    tmr_done_d  = (tmr_q == TW'(REQ_TIMEOUT - 1));
    gap_done_d  = (gap_q == '0);
    mem_we_d    = wr_en & ((state_q == ST_IDLE) |
                           ((state_q == ST_FILL) & ~buf_full_d));
    mem_waddr_d = (state_q == ST_IDLE) ? '0 : len_q;
  end

  gmac_tx_buf #(
    .AW (AW)
  ) u_buf (
    .clk_i   (clk125),
    .we_i    (mem_we_d),
    .waddr_i (mem_waddr_d),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk125) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      rd_ptr_q   <= '0;
      out_idx_q  <= '0;
      ovf_q      <= 1'b0;
      tmr_q      <= '0;
      gap_q      <= '0;
      req_q      <= 1'b0;
      val_q      <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      data_q     <= '0;
      tx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      // Stream outputs default low so SoF/EoF/Data are zero outside valid beats.
      val_q  <= 1'b0;
      sof_q  <= 1'b0;
      eof_q  <= 1'b0;
      data_q <= '0;

      case (state_q)
        ST_IDLE: begin
          if (wr_en) begin
            len_q <= AW'(1);
            ovf_q <= 1'b0;
            if (wr_last) begin
              state_q  <= ST_REQ;
              req_q    <= 1'b1;
              tmr_q    <= '0;
              rd_ptr_q <= '0;
            end else begin
              state_q <= ST_FILL;
            end
          end
        end

        ST_FILL: begin
          if (wr_en) begin
            if (buf_full_d) begin
              ovf_q <= 1'b1;
            end else begin
              len_q <= len_q + AW'(1);
            end
            // The overflowing byte may itself carry wr_last.
            if (wr_last) begin
              if (ovf_d) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
                ovf_q      <= 1'b0;
                len_q      <= '0;
                state_q    <= ST_IDLE;
              end else begin
                state_q  <= ST_REQ;
                req_q    <= 1'b1;
                tmr_q    <= '0;
                rd_ptr_q <= '0;
              end
            end
          end
        end

        ST_REQ: begin
          // Buffer is reading address 0 here, so byte 0 is ready one cycle after the grant.
          if (ReqConfirm) begin
            req_q     <= 1'b0;
            rd_ptr_q  <= AW'(1);
            out_idx_q <= '0;
            state_q   <= ST_SEND;
          end else if (tmr_done_d) begin
            req_q      <= 1'b0;
            drop_cnt_q <= drop_cnt_q + 16'd1;
            len_q      <= '0;
            state_q    <= ST_IDLE;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end

        ST_SEND: begin
          val_q     <= 1'b1;
          data_q    <= rd_data;
          sof_q     <= (out_idx_q == '0);
          eof_q     <= last_byte_d;
          out_idx_q <= out_idx_q + AW'(1);
          rd_ptr_q  <= rd_ptr_q + AW'(1);
          if (last_byte_d) begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
            gap_q    <= GW'(IFG_CYC);
            len_q    <= '0;
            state_q  <= ST_GAP;
          end
        end

        ST_GAP: begin
          // Entered during the EoF beat; the count covers the idle cycles after it.
          if (gap_done_d) begin
            state_q <= ST_IDLE;
          end else begin
            gap_q <= gap_q - GW'(1);
          end
        end

        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign wr_ready   = (state_q == ST_IDLE) || (state_q == ST_FILL);
  assign busy       = (state_q != ST_IDLE);
  assign ReqOut     = req_q;
  assign ValOut     = val_q;
  assign SoFOut     = sof_q;
  assign EoFOut     = eof_q;
  assign DataOut    = data_q;
  assign tx_pkt_cnt = tx_cnt_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_gmac_tx_feeder.sv
// Directed bench for gmac_tx_feeder: packet transfer, overflow, timeout, reset, IFG.
module tb_gmac_tx_feeder;

  logic        clk125 = 1'b0;
  logic        rstn;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        wr_last;
  logic        wr_ready;
  logic        ReqOut;
  logic        ReqConfirm;
  logic        ValOut;
  logic        SoFOut;
  logic        EoFOut;
  logic [7:0]  DataOut;
  logic        busy;
  logic [15:0] tx_pkt_cnt;
  logic [15:0] drop_cnt;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          req_hi = 0;
  int          val_cyc = 0;
  int          viol = 0;
  logic [15:0] exp_tx = '0;
  logic [15:0] exp_drop = '0;
  logic [7:0]  pay [0:15];

  gmac_tx_feeder dut (
    .clk125     (clk125),
    .rstn       (rstn),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_last    (wr_last),
    .wr_ready   (wr_ready),
    .ReqOut     (ReqOut),
    .ReqConfirm (ReqConfirm),
    .ValOut     (ValOut),
    .SoFOut     (SoFOut),
    .EoFOut     (EoFOut),
    .DataOut    (DataOut),
    .busy       (busy),
    .tx_pkt_cnt (tx_pkt_cnt),
    .drop_cnt   (drop_cnt)
  );

  always #4 clk125 = ~clk125;

  always @(negedge clk125) begin
    if (ReqOut) req_hi++;
    if (ValOut) val_cyc++;
    if (!ValOut && (SoFOut || EoFOut || DataOut != 8'h00)) viol++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk125);
    #1;
  endtask

  task automatic load_pkt(input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = pay[i];
      wr_last = (i == n - 1);
      tick();
    end
    wr_en   = 1'b0;
    wr_last = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!wr_ready && n < 200) begin
      n++;
      tick();
    end
    check_eq({tag, "_ready"}, wr_ready, 1);
  endtask

  // Load n bytes of pay[], grant gdly cycles after ReqOut rises, check the stream.
  task automatic xfer(input string tag, input int n, input int gdly);
    load_pkt(n);
    check_eq({tag, "_req_up"}, ReqOut, 1);
    check_eq({tag, "_rdy_low"}, wr_ready, 0);
    repeat (gdly) tick();
    ReqConfirm = 1'b1;
    tick();
    ReqConfirm = 1'b0;
    check_eq({tag, "_req_down"}, ReqOut, 0);
    check_eq({tag, "_val_early"}, ValOut, 0);
    tick();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_val%0d", tag, i), ValOut, 1);
      check_eq($sformatf("%s_data%0d", tag, i), DataOut, pay[i]);
      check_eq($sformatf("%s_sof%0d", tag, i), SoFOut, (i == 0));
      check_eq($sformatf("%s_eof%0d", tag, i), EoFOut, (i == n - 1));
      tick();
    end
    check_eq({tag, "_val_end"}, ValOut, 0);
    exp_tx = exp_tx + 16'd1;
    check_eq({tag, "_txcnt"}, tx_pkt_cnt, exp_tx);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int snap;
    rstn = 1'b0;
    wr_en = 1'b0;
    wr_data = '0;
    wr_last = 1'b0;
    ReqConfirm = 1'b0;
    repeat (3) tick();
    check_eq("rst_req", ReqOut, 0);
    check_eq("rst_val", ValOut, 0);
    check_eq("rst_data", DataOut, 0);
    check_eq("rst_ready", wr_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_tx", tx_pkt_cnt, 0);
    check_eq("rst_drop", drop_cnt, 0);
    rstn = 1'b1;
    tick();

    // 4-byte packet, grant 5 cycles after ReqOut rises
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    snap = req_hi;
    xfer("p4", 4, 5);
    check_eq("p4_req_cycles", req_hi - snap, 6);
    wait_ready("p4");

    // single byte, then IFG length measured from the EoF beat
    pay[0] = 8'hA5;
    xfer("p1", 1, 0);
    n = 0;
    while (!wr_ready && n < 50) begin
      n++;
      tick();
    end
    check_eq("p1_ifg_cycles", n, 12);

    // overflow: 1473 bytes into a 1472-byte buffer
    snap = req_hi;
    for (int i = 0; i < 1473; i++) begin
      wr_en   = 1'b1;
      wr_data = i[7:0];
      wr_last = (i == 1472);
      tick();
    end
    wr_en = 1'b0;
    wr_last = 1'b0;
    exp_drop = exp_drop + 16'd1;
    check_eq("ovf_drop", drop_cnt, exp_drop);
    check_eq("ovf_ready", wr_ready, 1);
    check_eq("ovf_busy", busy, 0);
    repeat (3) tick();
    check_eq("ovf_no_req", req_hi - snap, 0);
    pay[0] = 8'h5A; pay[1] = 8'hC3;
    xfer("p2", 2, 2);
    wait_ready("p2");

    // request timeout with ReqConfirm held low
    snap = val_cyc;
    pay[0] = 8'h77;
    load_pkt(1);
    n = 0;
    while (ReqOut && n < 5000) begin
      n++;
      tick();
    end
    check_eq("tmo_req_cycles", n, 4096);
    exp_drop = exp_drop + 16'd1;
    check_eq("tmo_drop", drop_cnt, exp_drop);
    check_eq("tmo_busy", busy, 0);
    check_eq("tmo_no_val", val_cyc - snap, 0);

    // reset during SEND at the third of ten bytes
    for (int i = 0; i < 10; i++) pay[i] = 8'h80 + 8'(i);
    load_pkt(10);
    ReqConfirm = 1'b1;
    tick();
    ReqConfirm = 1'b0;
    repeat (3) tick();
    check_eq("rs_mid_val", ValOut, 1);
    check_eq("rs_mid_data", DataOut, pay[2]);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check_eq("rs_val", ValOut, 0);
    check_eq("rs_eof", EoFOut, 0);
    check_eq("rs_data", DataOut, 0);
    check_eq("rs_req", ReqOut, 0);
    check_eq("rs_tx", tx_pkt_cnt, 0);
    check_eq("rs_drop", drop_cnt, 0);
    check_eq("rs_ready", wr_ready, 1);
    exp_tx = '0;
    exp_drop = '0;
    tick();
    check_eq("rs_eof_after", EoFOut, 0);
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
    xfer("p3", 3, 1);
    wait_ready("p3");

    // back-to-back: writes during GAP are ignored
    pay[0] = 8'hDE; pay[1] = 8'hAD;
    xfer("bb1", 2, 0);
    check_eq("bb_gap_ready", wr_ready, 0);
    snap = req_hi;
    load_pkt(2);
    check_eq("bb_gap_busy", busy, 1);
    wait_ready("bb");
    ReqConfirm = 1'b1;
    tick();
    ReqConfirm = 1'b0;
    repeat (2) tick();
    check_eq("bb_ignored_busy", busy, 0);
    check_eq("bb_ignored_req", req_hi - snap, 0);
    xfer("bb2", 2, 3);
    check_eq("bb_tx", tx_pkt_cnt, 3);
    wait_ready("bb2");

    check_eq("idle_stream_zero", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
